// File: rtl/vend_fsm_if.sv
// Coin/selection inputs and credit/refund outputs of the vending controller.
interface vend_fsm_if;
    logic       coin_5;
    logic       coin_10;
    logic       sel;
    logic       cancel;
    logic [5:0] credit;
    logic       dispense;
    logic [5:0] change;
    logic       change_vld;
    logic       coin_rej;
    logic       busy;

    modport master (
        output coin_5, coin_10, sel, cancel,
        input  credit, dispense, change, change_vld, coin_rej, busy
    );

    modport slave (
        input  coin_5, coin_10, sel, cancel,
        output credit, dispense, change, change_vld, coin_rej, busy
    );
endinterface

// File: rtl/vend_fsm.sv
// Vending machine controller: credit collection, timed dispense and refund.
// Optional feature: define REFUND_TIMEOUT_EN to auto-refund an idle COLLECT after TIMEOUT_TICKS ticks.
module vend_fsm #(
    parameter int PRICE         = 15,
    parameter int DISP_TICKS    = 2,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          tick_in,
    vend_fsm_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_RETURN} state_t;

    localparam logic [5:0]     PRICE_C   = 6'(PRICE);
    localparam int             DCW       = $clog2(DISP_TICKS + 1);
    localparam logic [DCW-1:0] DISP_LAST = DCW'(DISP_TICKS - 1);

    state_t         state_q, state_d;
    logic [5:0]     credit_q, credit_d;
    logic [5:0]     change_q, change_d;
    logic           vld_q, vld_d;
    logic           rej_q, rej_d;
    logic           disp_q, disp_d;
    logic           busy_q, busy_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic           sync1_q, sync2_q, sync3_q, tick_p_q;

    logic           coin_any;
    logic [5:0]     coin_val;
    logic [5:0]     remain;

`ifdef REFUND_TIMEOUT_EN
    localparam int             TCW      = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_TICKS - 1);
    logic [TCW-1:0] tcnt_q, tcnt_d;
`endif

    assign coin_any = bus.coin_5 | bus.coin_10;
    assign coin_val = (bus.coin_5 ? 6'd5 : 6'd0) + (bus.coin_10 ? 6'd10 : 6'd0);
    assign remain   = credit_q - PRICE_C;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = change_q;
        vld_d    = 1'b0;
        rej_d    = 1'b0;
        dcnt_d   = dcnt_q;
`ifdef REFUND_TIMEOUT_EN
        tcnt_d   = '0;
`endif
        case (state_q)
            S_IDLE: begin
                dcnt_d = '0;
                if (coin_any) begin
                    credit_d = credit_q + coin_val;
                    state_d  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.cancel) begin
                    state_d = S_RETURN;
                    rej_d   = coin_any;
                end else if (bus.sel && (credit_q >= PRICE_C)) begin
                    state_d = S_DISPENSE;
                    dcnt_d  = '0;
                    // Same-cycle coins count against the post-purchase balance.
                    if (coin_any && (remain < PRICE_C)) begin
                        credit_d = remain + coin_val;
                    end else begin
                        credit_d = remain;
                        rej_d    = coin_any;
                    end
                end else if (coin_any && (credit_q < PRICE_C)) begin
                    credit_d = credit_q + coin_val;
                end else begin
                    rej_d = coin_any;
`ifdef REFUND_TIMEOUT_EN
                    tcnt_d = tcnt_q;
                    if (tick_p_q) begin
                        if (tcnt_q == TMO_LAST) begin
                            state_d = S_RETURN;
                            tcnt_d  = '0;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
`endif
                end
            end
            S_DISPENSE: begin
                rej_d = coin_any;
                if (tick_p_q) begin
                    if (dcnt_q == DISP_LAST) begin
                        dcnt_d  = '0;
                        state_d = (credit_q != 6'd0) ? S_RETURN : S_IDLE;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
            end
            S_RETURN: begin
                rej_d    = coin_any;
                change_d = credit_q;
                vld_d    = 1'b1;
                credit_d = 6'd0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Status flags are registered from the next state so they line up with state_q.
        disp_d = (state_d == S_DISPENSE);
        busy_d = (state_d == S_DISPENSE) || (state_d == S_RETURN);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            credit_q <= 6'd0;
            change_q <= 6'd0;
            vld_q    <= 1'b0;
            rej_q    <= 1'b0;
            disp_q   <= 1'b0;
            busy_q   <= 1'b0;
            dcnt_q   <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            tick_p_q <= 1'b0;
`ifdef REFUND_TIMEOUT_EN
            tcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            vld_q    <= vld_d;
            rej_q    <= rej_d;
            disp_q   <= disp_d;
            busy_q   <= busy_d;
            dcnt_q   <= dcnt_d;
            sync1_q  <= tick_in;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            tick_p_q <= sync2_q & ~sync3_q;
`ifdef REFUND_TIMEOUT_EN
            tcnt_q   <= tcnt_d;
`endif
        end
    end

    assign bus.credit     = credit_q;
    assign bus.change     = change_q;
    assign bus.change_vld = vld_q;
    assign bus.coin_rej   = rej_q;
    assign bus.dispense   = disp_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_vend_fsm.sv
// Directed bench for vend_fsm with hand-computed expectations (PRICE=15, DISP_TICKS=2).
module tb_vend_fsm;
    logic clk;
    logic nrst;
    logic tick_in;
    int   checks;
    int   failures;
    int   vld_cnt;
    int   disp_cnt;
    int   snap_vld;
    int   snap_disp;

    vend_fsm_if bus ();

    vend_fsm #(.PRICE(15), .DISP_TICKS(2), .TIMEOUT_TICKS(10)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .tick_in (tick_in),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.change_vld === 1'b1) vld_cnt++;
        if (bus.dispense === 1'b1) disp_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic c5, input logic c10);
        bus.coin_5  = c5;
        bus.coin_10 = c10;
        step();
        bus.coin_5  = 1'b0;
        bus.coin_10 = 1'b0;
    endtask

    task automatic press(input logic s, input logic c);
        bus.sel    = s;
        bus.cancel = c;
        step();
        bus.sel    = 1'b0;
        bus.cancel = 1'b0;
    endtask

    // Four edges after the rise the FSM has consumed the synchronized tick.
    task automatic tick_rise();
        tick_in = 1'b1;
        repeat (4) step();
    endtask

    task automatic tick_fall();
        tick_in = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        checks = 0; failures = 0; vld_cnt = 0; disp_cnt = 0;
        nrst = 1'b0; tick_in = 1'b0;
        bus.coin_5 = 1'b0; bus.coin_10 = 1'b0; bus.sel = 1'b0; bus.cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_credit", bus.credit, 0);
        check("rst_change", bus.change, 0);
        check("rst_vld", bus.change_vld, 0);
        check("rst_disp", bus.dispense, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_rej", bus.coin_rej, 0);
        nrst = 1'b1;
        step();

        // Exact price: 10 + 5, buy, two ticks, back to idle without change
        snap_vld = vld_cnt;
        coin(1'b0, 1'b1);
        check("t1_credit10", bus.credit, 10);
        coin(1'b1, 1'b0);
        check("t1_credit15", bus.credit, 15);
        press(1'b1, 1'b0);
        check("t1_disp_on", bus.dispense, 1);
        check("t1_busy_on", bus.busy, 1);
        check("t1_credit0", bus.credit, 0);
        tick_rise();
        check("t1_disp_tick1", bus.dispense, 1);
        tick_fall();
        tick_rise();
        check("t1_disp_off", bus.dispense, 0);
        check("t1_busy_off", bus.busy, 0);
        tick_fall();
        check("t1_no_vld", vld_cnt - snap_vld, 0);

        // Overpay: 10 + 10, buy, change of 5
        coin(1'b0, 1'b1);
        coin(1'b0, 1'b1);
        check("t2_credit20", bus.credit, 20);
        press(1'b1, 1'b0);
        check("t2_credit5", bus.credit, 5);
        check("t2_disp_on", bus.dispense, 1);
        tick_rise();
        tick_fall();
        tick_rise();
        check("t2_return_busy", bus.busy, 1);
        check("t2_return_disp", bus.dispense, 0);
        check("t2_return_vld", bus.change_vld, 0);
        tick_in = 1'b0;
        step();
        check("t2_vld", bus.change_vld, 1);
        check("t2_change", bus.change, 5);
        check("t2_credit_clr", bus.credit, 0);
        check("t2_busy_off", bus.busy, 0);
        step();
        check("t2_vld_drop", bus.change_vld, 0);
        check("t2_change_hold", bus.change, 5);
        repeat (2) step();

        // Coin refused once credit reaches the price
        coin(1'b0, 1'b1);
        coin(1'b0, 1'b1);
        coin(1'b1, 1'b0);
        check("t3_credit_hold", bus.credit, 20);
        check("t3_rej", bus.coin_rej, 1);
        step();
        check("t3_rej_drop", bus.coin_rej, 0);
        press(1'b0, 1'b1);
        step();
        check("t3_vld", bus.change_vld, 1);
        check("t3_change", bus.change, 20);

        // Cancel wins over sel in the same cycle
        snap_disp = disp_cnt;
        coin(1'b1, 1'b0);
        check("t4_credit5", bus.credit, 5);
        press(1'b1, 1'b1);
        check("t4_busy", bus.busy, 1);
        check("t4_no_disp", bus.dispense, 0);
        step();
        check("t4_vld", bus.change_vld, 1);
        check("t4_change", bus.change, 5);
        check("t4_credit0", bus.credit, 0);
        check("t4_disp_never", disp_cnt - snap_disp, 0);

        // Both coins together, then sel with a same-cycle coin added after the subtraction
        coin(1'b1, 1'b1);
        check("t5_credit15", bus.credit, 15);
        bus.sel = 1'b1; bus.coin_10 = 1'b1;
        step();
        bus.sel = 1'b0; bus.coin_10 = 1'b0;
        check("t5_credit10", bus.credit, 10);
        check("t5_disp", bus.dispense, 1);
        check("t5_no_rej", bus.coin_rej, 0);
        tick_rise();
        tick_fall();
        tick_rise();
        tick_in = 1'b0;
        step();
        check("t5_vld", bus.change_vld, 1);
        check("t5_change", bus.change, 10);
        repeat (2) step();

        // Underpaid sel is ignored; then ten ticks of inactivity
        snap_vld = vld_cnt;
        coin(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("t6_sel_ignored_credit", bus.credit, 5);
        check("t6_sel_ignored_disp", bus.dispense, 0);
        for (int i = 0; i < 10; i++) begin
            tick_rise();
            tick_fall();
        end
`ifdef REFUND_TIMEOUT_EN
        check("t6_tmo_vld", vld_cnt - snap_vld, 1);
        check("t6_tmo_change", bus.change, 5);
        check("t6_tmo_credit", bus.credit, 0);
        check("t6_tmo_busy", bus.busy, 0);
`else
        check("t6_wait_credit", bus.credit, 5);
        check("t6_wait_vld", vld_cnt - snap_vld, 0);
        check("t6_wait_busy", bus.busy, 0);
        press(1'b0, 1'b1);
        step();
        check("t6_cancel_change", bus.change, 5);
`endif
        repeat (2) step();

        // Asynchronous reset in the middle of dispensing
        coin(1'b0, 1'b1);
        coin(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("t7_disp_on", bus.dispense, 1);
        check("t7_credit5", bus.credit, 5);
        snap_vld = vld_cnt;
        #2;
        nrst = 1'b0;
        #1;
        check("t7_async_disp", bus.dispense, 0);
        check("t7_async_credit", bus.credit, 0);
        check("t7_async_busy", bus.busy, 0);
        #3;
        nrst = 1'b1;
        step();
        check("t7_idle_busy", bus.busy, 0);
        check("t7_idle_credit", bus.credit, 0);
        check("t7_no_vld", vld_cnt - snap_vld, 0);
        coin(1'b1, 1'b0);
        check("t7_idle_coin", bus.credit, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vend_fsm.md
VEND_FSM -- requirements
Module: vend_fsm

Interface
REQ-001 Parameter PRICE, default 15: item price in credit units (multiple of 5, range 5..45).
REQ-002 Parameter DISP_TICKS, default 2: tick edges for which dispense stays asserted.
REQ-003 Parameter TIMEOUT_TICKS, default 10: idle tick edges in COLLECT before auto-refund.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 tick_in  input  1  divided clock from fdiv (div_clk), treated as an asynchronous level.
REQ-007 coin_5  input  1  one-cycle pulse, coin worth 5.
REQ-008 coin_10  input  1  one-cycle pulse, coin worth 10.
REQ-009 sel  input  1  one-cycle pulse, purchase request.
REQ-010 cancel  input  1  one-cycle pulse, refund request.
REQ-011 credit  output  6  current accumulated credit.
REQ-012 dispense  output  1  motor drive, high throughout the DISPENSE state.
REQ-013 change  output  6  refund amount, valid only while change_vld is high.
REQ-014 change_vld  output  1  one-cycle pulse qualifying change.
REQ-015 coin_rej  output  1  one-cycle pulse, coin refused.
REQ-016 busy  output  1  high in DISPENSE or RETURN.

Function
REQ-017 tick_in SHALL pass through a 2-flop synchronizer plus rising-edge detector; the internal tick_p pulse occurs 3 clk edges after the tick_in rise.
REQ-018 States: IDLE, COLLECT, DISPENSE, RETURN; encoding is free.
REQ-019 Same-cycle input priority: cancel > sel > coins.
REQ-020 IDLE: any coin adds its value to credit and the FSM goes to COLLECT on the next edge.
REQ-021 COLLECT, coins: accepted only while credit < PRICE; coin_5 and coin_10 asserted together add 15.
REQ-022 COLLECT, refused coins: coins arriving with credit >= PRICE leave credit unchanged and pulse coin_rej on the next cycle.
REQ-023 COLLECT, sel: with credit >= PRICE, go to DISPENSE and set credit <= credit - PRICE; with credit < PRICE, sel is ignored.
REQ-024 COLLECT, coins with a successful sel: coins in the same cycle are still added, after the subtraction.
REQ-025 COLLECT, cancel: go to RETURN.
REQ-026 DISPENSE: dispense=1; count tick_p edges; on the DISP_TICKS-th edge, go to RETURN if credit != 0, else IDLE.
REQ-027 DISPENSE: all coin, sel and cancel inputs are ignored; coins pulse coin_rej.
REQ-028 RETURN, single cycle: change <= credit, change_vld=1, credit <= 0; next state IDLE.
REQ-029 RETURN with credit 0 (cancel from an empty COLLECT is impossible): change_vld still pulses with change=0.
REQ-030 credit SHALL never exceed PRICE+10; no wrap-around is possible at 6 bits.
REQ-031 Outputs are registered; change holds its last value when change_vld=0.

Reset
REQ-032 nrst low asynchronously forces IDLE, credit=0, change=0, and all pulses, dispense, busy, synchronizer flops and tick counters to 0.
REQ-033 Reset mid-DISPENSE drops dispense immediately and forfeits credit; no change_vld is generated.

Configuration
REQ-034 With REFUND_TIMEOUT_EN defined, COLLECT counts tick_p edges, clears the count on any accepted coin, and enters RETURN on the TIMEOUT_TICKS-th edge.
REQ-035 With REFUND_TIMEOUT_EN undefined, there is no timeout counter and COLLECT waits indefinitely.

Verification
REQ-036 coin_10, coin_5, sel -> credit 10, then 15; DISPENSE for 2 tick edges; then IDLE; no change_vld.
REQ-037 coin_10, coin_10, sel -> credit 20; dispense; then change_vld with change=5; credit 0.
REQ-038 coin_10, coin_10, coin_5 (credit 20 >= 15) -> third coin refused, coin_rej pulses, credit stays 20.
REQ-039 coin_5, then sel+cancel in the same cycle -> RETURN with change=5; dispense never asserted.
REQ-040 REFUND_TIMEOUT_EN, coin_5 then 10 tick_in rises -> change_vld, change=5, IDLE; without the macro -> credit stays 5.
REQ-041 nrst pulsed low mid-DISPENSE -> dispense=0 and credit=0 without waiting for a clk edge; next state IDLE.
